// File: rtl/bin2bcd_converter.sv
// rtl/bin2bcd_converter.sv - sequential double-dabble binary to packed BCD converter
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     conversion request, honoured in IDLE and on the edge leaving DONE
//   value     unsigned binary operand, captured when start is accepted
//   busy      high while converting or presenting the result (CONVERT, DONE)
//   done      one-cycle pulse when bcd_out/overflow are updated
//   bcd_out   packed BCD result, [3:0] ones .. [31:28] ten-millions
//   overflow  last converted value did not fit in eight decimal digits

module bin2bcd_converter #(
    parameter int          IN_WIDTH = 32,
    parameter logic [31:0] OVF_CODE = 32'hEEEE_EEEE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] value,
    output logic                busy,
    output logic                done,
    output logic [31:0]         bcd_out,
    output logic                overflow
);

    localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int CMP_W = (IN_WIDTH > 32) ? IN_WIDTH : 32;
    localparam logic [CMP_W-1:0] MAX_DEC   = CMP_W'(99_999_999);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IN_WIDTH-1:0] bin_q;
    logic [IN_WIDTH-1:0] bin_shift;
    logic [31:0]         acc_q;
    logic [31:0]         acc_adj;
    logic [31:0]         acc_shift;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_pending_q;
    logic [CMP_W-1:0]    value_ext;
    logic                accept;
    logic                finish;

    assign value_ext = CMP_W'(value);

    // Add-3 correction on every nibble >= 5 so the following left shift
    // carries correctly into the next decimal digit.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 8; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Joint shift of {accumulator, binary}; the accumulator MSB falls off,
    // which only matters for values already flagged as overflow.
    assign acc_shift = {acc_adj[30:0], bin_q[IN_WIDTH-1]};
    assign bin_shift = bin_q << 1;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt_q == LAST_ITER) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // The edge leaving DONE may accept the next request, so a held
                // start yields one conversion every IN_WIDTH+1 clocks.
                if (start) begin
                    accept     = 1'b1;
                    state_next = S_CONVERT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            bin_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            bcd_out       <= '0;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                bin_q         <= value;
                acc_q         <= '0;
                cnt_q         <= '0;
                ovf_pending_q <= (value_ext > MAX_DEC);
            end else if (state == S_CONVERT) begin
                bin_q <= bin_shift;
                acc_q <= acc_shift;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Outputs move only on the edge that raises done.
            if (finish) begin
                bcd_out  <= ovf_pending_q ? OVF_CODE : acc_shift;
                overflow <= ovf_pending_q;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// tb/tb_bin2bcd_converter.sv - self-checking bench for bin2bcd_converter

module tb_bin2bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    bin2bcd_converter #(
        .IN_WIDTH(32),
        .OVF_CODE(32'hEEEE_EEEE)
    ) dut (
        .clk     (clk),
        .rst     (rst_n),
        .start   (start),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_bcd(input logic [31:0] v);
        logic [31:0]     r;
        longint unsigned x;
        if (v > 32'd99_999_999) return 32'hEEEE_EEEE;
        r = '0;
        x = longint'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [31:0] v, input string tag);
        int n;
        bit busy_ok;
        start = 1'b1;
        value = v;
        step();
        start = 1'b0;
        value = $urandom;
        busy_ok = 1'b1;
        n = 0;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            step();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd32);
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " bcd"}, bcd_out, model_bcd(v));
        check({tag, " ovf"}, {31'b0, overflow}, {31'b0, (v > 32'd99_999_999)});
        step();
        check({tag, " done_len"}, {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        int          n;
        int          dones;
        bit          stable;
        logic [31:0] got;
        logic [31:0] last;
        logic [31:0] seq_vals [3];
        logic [31:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        #12;
        check("reset outs", {busy, done, overflow, 29'b0}, 32'd0);
        check("reset bcd", bcd_out, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run_conv(32'd0, "zero");
        run_conv(32'd12_345_678, "12345678");
        run_conv(32'd99_999_999, "max");
        run_conv(32'd9, "nine");
        run_conv(32'd100_000_000, "ovf_min");
        run_conv(32'hFFFF_FFFF, "ovf_all");

        for (int i = 0; i < 8; i++) begin
            rv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 99_999_999));
            run_conv(rv, $sformatf("rand%0d", i));
        end

        // start during conversion is ignored
        start = 1'b1;
        value = 32'd4096;
        step();
        start = 1'b0;
        repeat (9) step();
        start = 1'b1;
        value = 32'd777;
        step();
        start = 1'b0;
        dones = 0;
        got = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                dones++;
                got = bcd_out;
            end
            step();
        end
        check("ignore dones", 32'(dones), 32'd1);
        check("ignore bcd", got, 32'h0000_4096);

        // asynchronous reset mid-conversion
        start = 1'b1;
        value = 32'd55_555_555;
        step();
        start = 1'b0;
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        check("abort outs", {busy, done, overflow, 29'b0}, 32'd0);
        check("abort bcd", bcd_out, 32'd0);
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            step();
        end
        check("abort no done", 32'(dones), 32'd0);
        check("abort bcd held", bcd_out, 32'd0);
        run_conv(32'($urandom_range(0, 99_999_999)), "after_abort");

        // start held high: back-to-back conversions
        seq_vals[0] = 32'd1;
        seq_vals[1] = 32'd22;
        seq_vals[2] = 32'd333;
        start = 1'b1;
        value = seq_vals[0];
        step();
        last = bcd_out;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            stable = 1'b1;
            do begin
                step();
                n++;
                if (!done && bcd_out !== last) stable = 1'b0;
            end while (!done && n < 40);
            check($sformatf("held period%0d", k), 32'(n), (k == 0) ? 32'd32 : 32'd33);
            check($sformatf("held bcd%0d", k), bcd_out, model_bcd(seq_vals[k]));
            check($sformatf("held stable%0d", k), {31'b0, stable}, 32'd1);
            last = bcd_out;
            if (k < 2) value = seq_vals[k + 1];
            else start = 1'b0;
        end
        step();
        check("held idle", {31'b0, busy}, 32'd0);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
